// File: rtl/uart_receiver.sv
// uart_receiver: oversampling receiver for 7-bit frames (start, 7 data LSB first, parity, stop).
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rxd,
    output logic [6:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [6:0]    shreg, shreg_n;
    logic          par, par_n;
    logic          done;

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bidx       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rxs        <= rx_meta;
            state      <= state_n;
            cnt        <= cnt_n;
            bidx       <= bidx_n;
            shreg      <= shreg_n;
            par        <= par_n;
            data_valid <= done;
            if (done) begin
                data_out   <= shreg;
                parity_err <= (^shreg ^ par) != PARITY_ODD;
                frame_err  <= ~rxs;
            end
        end
    end

    // Everything below only moves on a sample tick; mid-bit sampling happens at the counter wrap.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        par_n   = par;
        done    = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == MID) begin
                        state_n = rxs ? IDLE : DATA;
                        cnt_n   = '0;
                        bidx_n  = '0;
                    end
                end
                DATA: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == LAST) begin
                        shreg_n = {rxs, shreg[6:1]};
                        cnt_n   = '0;
                        bidx_n  = bidx + 3'd1;
                        state_n = (bidx == 3'd6) ? PARITY : DATA;
                    end
                end
                PARITY: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == LAST) begin
                        par_n   = rxs;
                        cnt_n   = '0;
                        state_n = STOP;
                    end
                end
                STOP: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == LAST) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = rxs ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into an even- and an odd-parity receiver, checked against a frame-queue model.
module tb_uart_receiver;
    localparam int OS = 16;

    typedef struct packed {
        logic [6:0] d;
        logic       p;
        logic       s;
    } frame_t;

    logic       clk = 1'b0, rst = 1'b1, sample_tick = 1'b1, rxd = 1'b1;
    logic [6:0] do0, do1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, bz0, bz1;
    int         checks = 0, errors = 0, cyc = 0, dv_cyc = 0, pulses = 0, c0 = 0;
    frame_t     q0[$], q1[$];
    frame_t     f0, f1;
    logic [6:0] md0 = '0, md1 = '0;
    logic       mpe0 = 1'b0, mpe1 = 1'b0, mfe0 = 1'b0, mfe1 = 1'b0;

    uart_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd),
        .data_out(do0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(bz0)
    );
    uart_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd),
        .data_out(do1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(bz1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // A frame has a parity error when the count of ones over data+parity disagrees with the selected rule.
    function automatic logic pe_of(input frame_t f, input logic odd);
        return (($countones({f.d, f.p}) % 2) == 1) != odd;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            md0 = '0; md1 = '0; mpe0 = 1'b0; mpe1 = 1'b0; mfe0 = 1'b0; mfe1 = 1'b0;
        end else begin
            if (dv0) begin
                pulses++;
                dv_cyc = cyc;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_even actual=1 required=0 (no frame pending)");
                end else begin
                    f0 = q0.pop_front();
                    md0 = f0.d; mpe0 = pe_of(f0, 1'b0); mfe0 = !f0.s;
                end
            end
            if (dv1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_odd actual=1 required=0 (no frame pending)");
                end else begin
                    f1 = q1.pop_front();
                    md1 = f1.d; mpe1 = pe_of(f1, 1'b1); mfe1 = !f1.s;
                end
            end
            chk("data_out_even", 32'(do0), 32'(md0));
            chk("parity_err_even", 32'(pe0), 32'(mpe0));
            chk("frame_err_even", 32'(fe0), 32'(mfe0));
            chk("data_out_odd", 32'(do1), 32'(md1));
            chk("parity_err_odd", 32'(pe1), 32'(mpe1));
            chk("frame_err_odd", 32'(fe1), 32'(mfe1));
        end
    end

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] d, input logic p, input logic s);
        q0.push_back('{d, p, s});
        q1.push_back('{d, p, s});
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic tx(input logic [6:0] d);
        send(d, logic'($countones(d) % 2), 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(do0), 32'h0);
        chk("rst_valid", 32'(dv0), 32'h0);
        chk("rst_parity_err", 32'(pe0), 32'h0);
        chk("rst_frame_err", 32'(fe0), 32'h0);
        chk("rst_busy", 32'(bz0), 32'h0);
        rst = 1'b0;
        idle(5);

        c0 = cyc;
        send(7'h55, 1'b0, 1'b1);
        idle(20);
        // 2 synchronizer clocks + 1 detect clock + 152 ticks to the stop sample
        chk("latency", 32'(dv_cyc - c0), 32'd155);
        chk("f55_data", 32'(do0), 32'h55);
        chk("f55_perr", 32'(pe0), 32'h0);
        chk("f55_ferr", 32'(fe0), 32'h0);
        chk("f55_busy", 32'(bz0), 32'h0);

        send(7'h01, 1'b0, 1'b1);
        idle(20);
        chk("f01_data", 32'(do0), 32'h01);
        chk("f01_perr_even", 32'(pe0), 32'h1);
        chk("f01_perr_odd", 32'(pe1), 32'h0);
        chk("f01_ferr", 32'(fe0), 32'h0);

        send(7'h7F, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        chk("break_busy", 32'(bz0), 32'h1);
        chk("break_ferr", 32'(fe0), 32'h1);
        chk("break_data", 32'(do0), 32'h7F);
        idle(OS);
        chk("break_release_busy", 32'(bz0), 32'h0);
        send(7'h2A, 1'b1, 1'b1);
        idle(20);
        chk("f2a_data", 32'(do0), 32'h2A);
        chk("f2a_ferr", 32'(fe0), 32'h0);

        rxd = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch_busy_mid", 32'(bz0), 32'h1);
        idle(20);
        chk("glitch_busy_end", 32'(bz0), 32'h0);
        chk("glitch_data", 32'(do0), 32'h2A);

        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(bz0), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_data", 32'(do0), 32'h0);
        chk("abort_valid", 32'(dv0), 32'h0);
        chk("abort_perr", 32'(pe0), 32'h0);
        chk("abort_ferr", 32'(fe0), 32'h0);
        chk("abort_busy", 32'(bz0), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        tx(7'h33);
        idle(20);
        chk("f33_data", 32'(do0), 32'h33);

        tx(7'h00);
        tx(7'h7F);
        tx(7'h5A);
        idle(40);
        chk("loop_data", 32'(do0), 32'h5A);
        chk("pulse_count", 32'(pulses), 32'd8);
        chk("queue_even_drained", 32'(q0.size()), 32'd0);
        chk("queue_odd_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
